pipe_control: RTL

Pipelined control unit for the 32-bit datapath. It decodes the opcode and register fields of the instruction in ID and carries the control word through EX, MEM and WB pipeline registers. It detects load-use hazards and stalls fetch/decode for them. It resolves branches and jumps in EX and flushes the wrong-path instruction. It sits between the instruction register and the datapath, taking the EX-stage z/n flags back from the ALU.

---
 rtl/pipe_control.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// pipe_control: ID decode plus EX/MEM/WB control pipeline with
// load-use stall and EX-stage branch/jump resolution.
module pipe_control #(
    parameter int OPW   = 4,
    parameter int REGW  = 6,
    parameter int INSTW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic [INSTW-1:0] inst,
    input  logic             z,
    input  logic             n,
    output logic             stall,
    output logic             flush,
    output logic             pc_sel,
    output logic             ex_alusrc,
    output logic [2:0]       ex_aluop,
    output logic             ex_svpc,
    output logic             mem_memr,
    output logic             mem_memw,
    output logic             wb_regw,
    output logic             wb_memtoreg,
    output logic [REGW-1:0]  wb_rd,
    output logic             ex_illegal
);

    typedef struct packed {
        logic       alusrc;
        logic [2:0] aluop;
        logic       svpc;
        logic       memr;
        logic       memw;
        logic       regw;
        logic       memtoreg;
    } ctl_t;

    // Zero-extended compares make non-zero upper opcode bits illegal.
    localparam logic [OPW-1:0] OP_NOP  = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ST   = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_INC  = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_J    = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_BRZ  = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_BRN  = OPW'(4'hB);
    localparam logic [OPW-1:0] OP_LD   = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_SVPC = OPW'(4'hF);

    logic [OPW-1:0]  id_op;
    logic [REGW-1:0] id_rd;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;

    assign id_op = inst[INSTW-1 -: OPW];
    assign id_rd = inst[INSTW-OPW-1 -: REGW];
    assign id_rs = inst[INSTW-OPW-REGW-1 -: REGW];
    assign id_rt = inst[INSTW-OPW-2*REGW-1 -: REGW];

    if (INSTW > OPW + 3*REGW) begin : g_unused
        wire unused_lo = ^inst[INSTW-OPW-3*REGW-1:0];
    end

    ctl_t id_ctl;
    logic id_ill;

    always_comb begin
        id_ctl = '0;
        id_ill = 1'b0;
        unique case (1'b1)
            id_op == OP_ADD: begin
                id_ctl.aluop = 3'b001;
                id_ctl.regw  = 1'b1;
            end
            id_op == OP_INC: begin
                id_ctl.aluop  = 3'b001;
                id_ctl.alusrc = 1'b1;
                id_ctl.regw   = 1'b1;
            end
            id_op == OP_SVPC: begin
                id_ctl.aluop  = 3'b001;
                id_ctl.alusrc = 1'b1;
                id_ctl.svpc   = 1'b1;
                id_ctl.regw   = 1'b1;
            end
            id_op == OP_NEG: begin
                id_ctl.aluop = 3'b010;
                id_ctl.regw  = 1'b1;
            end
            id_op == OP_SUB: begin
                id_ctl.aluop = 3'b100;
                id_ctl.regw  = 1'b1;
            end
            id_op == OP_LD: begin
                id_ctl.memr     = 1'b1;
                id_ctl.memtoreg = 1'b1;
                id_ctl.regw     = 1'b1;
            end
            id_op == OP_ST:  id_ctl.memw = 1'b1;
            id_op == OP_NOP, id_op == OP_J,
            id_op == OP_BRZ, id_op == OP_BRN: ;
            default: id_ill = 1'b1;
        endcase
    end

    logic            ex_v;
    ctl_t            ex_c;
    logic [OPW-1:0]  ex_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_ill;
    logic            mem_v;
    logic            mem_r;
    logic            mem_w;
    logic            mem_rw;
    logic            mem_m2r;
    logic [REGW-1:0] mem_rd;
    logic            wb_v;
    logic            wb_rw;
    logic            wb_m2r;
    logic [REGW-1:0] wb_rdq;

    logic hit;
    logic take;
    logic id_go;

    // ST reads rd as its store data, so rd joins the compare.
    assign hit = (ex_rd == id_rs) | (ex_rd == id_rt)
               | ((id_op == OP_ST) & (ex_rd == id_rd));
    assign stall = inst_valid & ex_v & (ex_op == OP_LD) & hit;

    assign take = ex_v & ((ex_op == OP_J)
                | ((ex_op == OP_BRZ) & z)
                | ((ex_op == OP_BRN) & n));
    assign flush  = take;
    assign pc_sel = take;
    assign id_go  = inst_valid & ~stall & ~take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v    <= 1'b0;
            ex_c    <= '0;
            ex_op   <= '0;
            ex_rd   <= '0;
            ex_ill  <= 1'b0;
            mem_v   <= 1'b0;
            mem_r   <= 1'b0;
            mem_w   <= 1'b0;
            mem_rw  <= 1'b0;
            mem_m2r <= 1'b0;
            mem_rd  <= '0;
            wb_v    <= 1'b0;
            wb_rw   <= 1'b0;
            wb_m2r  <= 1'b0;
            wb_rdq  <= '0;
        end else begin
            ex_v    <= id_go;
            ex_c    <= id_ctl;
            ex_op   <= id_op;
            ex_rd   <= id_rd;
            ex_ill  <= id_ill;
            mem_v   <= ex_v;
            mem_r   <= ex_c.memr;
            mem_w   <= ex_c.memw;
            mem_rw  <= ex_c.regw;
            mem_m2r <= ex_c.memtoreg;
            mem_rd  <= ex_rd;
            wb_v    <= mem_v;
            wb_rw   <= mem_rw;
            wb_m2r  <= mem_m2r;
            wb_rdq  <= mem_rd;
        end
    end

    assign ex_alusrc   = ex_v & ex_c.alusrc;
    assign ex_aluop    = ex_v ? ex_c.aluop : 3'b000;
    assign ex_svpc     = ex_v & ex_c.svpc;
    assign ex_illegal  = ex_v & ex_ill;
    assign mem_memr    = mem_v & mem_r;
    assign mem_memw    = mem_v & mem_w;
    assign wb_regw     = wb_v & wb_rw;
    assign wb_memtoreg = wb_v & wb_m2r;
    assign wb_rd       = wb_v ? wb_rdq : '0;

endmodule
